// File: rtl/ppu_seq_ctrl.sv
// PPU sequencer: streams psum words through the PPU and packs
// int8 pairs into dense OFM words under a ready handshake.
module ppu_seq_ctrl #(
  parameter int ADDR_BITS = 16,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] cfg_src_base,
  input  logic [ADDR_BITS-1:0] cfg_dst_base,
  input  logic [LEN_BITS-1:0]  cfg_len,
  input  logic [5:0]           cfg_scale,
  input  logic                 cfg_relu_en,
  output logic                 busy,
  output logic                 done,
  output logic                 psum_rd_en,
  output logic [ADDR_BITS-1:0] psum_rd_addr,
  input  logic [DATA_BITS-1:0] psum_rd_data,
  output logic [DATA_BITS-1:0] ppu_data_in,
  output logic [5:0]           ppu_scaling_factor,
  output logic                 ppu_relu_en,
  output logic                 ppu_need_ppu,
  output logic [3:0]           ppu_WEB,
  input  logic [DATA_BITS-1:0] ppu_data_out,
  output logic                 ofm_wr_en,
  output logic [ADDR_BITS-1:0] ofm_wr_addr,
  output logic [DATA_BITS-1:0] ofm_wr_data,
  output logic [3:0]           ofm_byte_en,
  input  logic                 ofm_wr_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_WR, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_BITS-1:0] src_base_q;
  logic [ADDR_BITS-1:0] dst_base_q;
  logic [LEN_BITS-1:0]  len_q;
  logic [5:0]           scale_q;
  logic                 relu_q;
  logic [LEN_BITS-1:0]  i_q;
  logic [ADDR_BITS-1:0] dst_idx_q;
  logic [31:0]          pack_q;
  logic                 wr_en_q;
  logic [ADDR_BITS-1:0] wr_addr_q;
  logic [3:0]           be_q;

  logic [LEN_BITS-1:0]  i_inc;
  logic                 last;
  logic                 flush;
  logic [15:0]          r;
  logic                 unused_ppu;

  assign i_inc = i_q + LEN_BITS'(1);
  assign last  = (i_inc == len_q);
  // A pair is complete on odd i; a lone trailing word flushes too.
  assign flush = i_q[0] | last;
  assign r     = {ppu_data_out[23:16], ppu_data_out[7:0]};
  assign unused_ppu = ^{ppu_data_out[31:24], ppu_data_out[15:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:
        if (start)
          state_nxt = (cfg_len != '0) ? S_RD : S_DONE;
      S_RD:   state_nxt = S_CAP;
      S_CAP:  state_nxt = flush ? S_WR : S_RD;
      S_WR:
        if (ofm_wr_ready)
          state_nxt = (i_q < len_q) ? S_RD : S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_base_q <= '0;
      dst_base_q <= '0;
      len_q      <= '0;
      scale_q    <= '0;
      relu_q     <= 1'b0;
      i_q        <= '0;
      dst_idx_q  <= '0;
      pack_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      be_q       <= '0;
    end else begin
      unique case (state)
        S_IDLE:
          if (start) begin
            src_base_q <= cfg_src_base;
            dst_base_q <= cfg_dst_base;
            len_q      <= cfg_len;
            scale_q    <= cfg_scale;
            relu_q     <= cfg_relu_en;
            i_q        <= '0;
            dst_idx_q  <= '0;
            pack_q     <= '0;
          end
        S_CAP: begin
          i_q <= i_inc;
          if (i_q[0]) pack_q[31:16] <= r;
          else        pack_q[15:0]  <= r;
          if (flush) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= dst_base_q + dst_idx_q;
            be_q      <= i_q[0] ? 4'b1111 : 4'b0011;
          end
        end
        S_WR:
          if (ofm_wr_ready) begin
            wr_en_q   <= 1'b0;
            be_q      <= '0;
            dst_idx_q <= dst_idx_q + ADDR_BITS'(1);
            pack_q    <= '0;
          end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    psum_rd_en   = 1'b0;
    psum_rd_addr = '0;
    ppu_data_in  = '0;
    unique case (state)
      S_RD: begin
        busy         = 1'b1;
        psum_rd_en   = 1'b1;
        psum_rd_addr = src_base_q + ADDR_BITS'(i_q);
      end
      S_CAP: begin
        busy        = 1'b1;
        ppu_data_in = psum_rd_data;
      end
      S_WR:   busy = 1'b1;
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign ppu_scaling_factor = scale_q;
  assign ppu_relu_en        = relu_q;
  assign ppu_need_ppu       = busy;
  assign ppu_WEB            = busy ? 4'b1111 : 4'b0000;
  assign ofm_wr_en          = wr_en_q;
  assign ofm_wr_addr        = wr_addr_q;
  assign ofm_wr_data        = pack_q;
  assign ofm_byte_en        = be_q;

endmodule

// File: tb/tb_ppu_seq_ctrl.sv
// Directed bench for ppu_seq_ctrl with a behavioural PPU and
// psum SRAM; expected OFM words are hand-computed constants.
module tb_ppu_seq_ctrl;
  localparam int AB = 16;
  localparam int DB = 32;
  localparam int LB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] cfg_src_base = '0;
  logic [AB-1:0] cfg_dst_base = '0;
  logic [LB-1:0] cfg_len = '0;
  logic [5:0]    cfg_scale = '0;
  logic          cfg_relu_en = 1'b0;
  logic          busy, done, psum_rd_en;
  logic [AB-1:0] psum_rd_addr;
  logic [DB-1:0] psum_rd_data = '0;
  logic [DB-1:0] ppu_data_in;
  logic [5:0]    ppu_scaling_factor;
  logic          ppu_relu_en, ppu_need_ppu;
  logic [3:0]    ppu_WEB;
  logic [DB-1:0] ppu_data_out;
  logic          ofm_wr_en;
  logic [AB-1:0] ofm_wr_addr;
  logic [DB-1:0] ofm_wr_data;
  logic [3:0]    ofm_byte_en;
  logic          ofm_wr_ready = 1'b1;

  ppu_seq_ctrl #(.ADDR_BITS(AB), .DATA_BITS(DB), .LEN_BITS(LB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
    .cfg_len(cfg_len), .cfg_scale(cfg_scale),
    .cfg_relu_en(cfg_relu_en), .busy(busy), .done(done),
    .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
    .psum_rd_data(psum_rd_data), .ppu_data_in(ppu_data_in),
    .ppu_scaling_factor(ppu_scaling_factor),
    .ppu_relu_en(ppu_relu_en), .ppu_need_ppu(ppu_need_ppu),
    .ppu_WEB(ppu_WEB), .ppu_data_out(ppu_data_out),
    .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr),
    .ofm_wr_data(ofm_wr_data), .ofm_byte_en(ofm_byte_en),
    .ofm_wr_ready(ofm_wr_ready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];

  always @(posedge clk)
    if (psum_rd_en) psum_rd_data <= mem[psum_rd_addr];

  // shift, optional ReLU, saturate, +128 zero point
  function automatic logic [7:0] q8(input logic [15:0] v,
                                    input logic [5:0] sh,
                                    input logic relu);
    int x;
    x = int'(signed'(v));
    x = x >>> sh;
    if (relu && x < 0) x = 0;
    if (x > 127) x = 127;
    if (x < -128) x = -128;
    return 8'(x + 128);
  endfunction

  always_comb
    ppu_data_out = {8'h00,
      q8(ppu_data_in[31:16], ppu_scaling_factor, ppu_relu_en),
      8'h00,
      q8(ppu_data_in[15:0], ppu_scaling_factor, ppu_relu_en)};

  int n_busy = 0, n_rd = 0, n_done = 0, stable_err = 0;
  int wr_seen = 0, stall_n = 0;
  logic [AB-1:0] ref_a;
  logic [DB-1:0] ref_d;
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] q_be[$];

  always @(negedge clk) begin
    if (busy) n_busy++;
    if (psum_rd_en) n_rd++;
    if (done) n_done++;
    if (ofm_wr_en) begin
      if (wr_seen == 0) begin
        ref_a = ofm_wr_addr;
        ref_d = ofm_wr_data;
      end else if (ofm_wr_addr != ref_a || ofm_wr_data != ref_d)
        stable_err++;
      ofm_wr_ready = (wr_seen >= stall_n);
      wr_seen++;
    end else begin
      wr_seen = 0;
      ofm_wr_ready = 1'b1;
    end
    if (ofm_wr_en && ofm_wr_ready) begin
      q_addr.push_back(32'(ofm_wr_addr));
      q_data.push_back(ofm_wr_data);
      q_be.push_back(32'(ofm_byte_en));
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  int b_busy, b_rd, b_done, b_wr, b_st;

  task automatic snap();
    b_busy = n_busy;
    b_rd   = n_rd;
    b_done = n_done;
    b_wr   = q_data.size();
    b_st   = stable_err;
  endtask

  task automatic kick(input logic [15:0] src, input logic [15:0] dst,
                      input logic [15:0] len, input logic [5:0] sc,
                      input logic relu);
    @(negedge clk);
    cfg_src_base = src;
    cfg_dst_base = dst;
    cfg_len      = len;
    cfg_scale    = sc;
    cfg_relu_en  = relu;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (!done && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input int k,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] be);
    chk({tag, "_present"}, 32'(q_data.size() > k), 32'd1);
    if (q_data.size() > k) begin
      chk({tag, "_addr"}, q_addr[k], a);
      chk({tag, "_data"}, q_data[k], d);
      chk({tag, "_be"}, q_be[k], be);
    end
  endtask

  task automatic chk_cnt(input string tag, input int busy_c,
                         input int rd_c, input int wr_c);
    chk({tag, "_busy_cyc"}, 32'(n_busy - b_busy), 32'(busy_c));
    chk({tag, "_rd_cnt"}, 32'(n_rd - b_rd), 32'(rd_c));
    chk({tag, "_done_cnt"}, 32'(n_done - b_done), 32'd1);
    chk({tag, "_wr_cnt"}, 32'(q_data.size() - b_wr), 32'(wr_c));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"},
        {16'h0, busy, done, psum_rd_en, ppu_relu_en, ppu_need_ppu,
         ppu_WEB, ofm_wr_en, ofm_byte_en, ppu_scaling_factor}, 32'h0);
    chk({tag, "_rd_addr"}, 32'(psum_rd_addr), 32'h0);
    chk({tag, "_ppu_in"}, ppu_data_in, 32'h0);
    chk({tag, "_wr_addr"}, 32'(ofm_wr_addr), 32'h0);
    chk({tag, "_wr_data"}, ofm_wr_data, 32'h0);
  endtask

  int lat, w;

  initial begin
    for (int k = 0; k < 65536; k++) mem[k] = 32'h0;
    mem[16'h0010] = 32'h0040_0100;
    mem[16'h0011] = 32'hFF00_FF00;
    mem[16'hFFFE] = 32'h0040_0100;
    mem[16'hFFFF] = 32'hFF00_FF00;
    mem[16'h0000] = 32'h7FFF_8000;

    #1;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    snap();
    kick(16'h0010, 16'h0040, 16'd2, 6'd2, 1'b1);
    wait_done("pair", lat);
    chk("pair_latency", 32'(lat), 32'd6);
    chk_cnt("pair", 5, 2, 1);
    chk_wr("pair_w0", b_wr, 32'h40, 32'h8080_90C0, 32'hF);

    snap();
    kick(16'h0010, 16'h0040, 16'd2, 6'd2, 1'b0);
    wait_done("norelu", lat);
    chk_cnt("norelu", 5, 2, 1);
    chk_wr("norelu_w0", b_wr, 32'h40, 32'h4040_90C0, 32'hF);

    snap();
    kick(16'hFFFE, 16'hFFFF, 16'd3, 6'd0, 1'b0);
    wait_done("odd", lat);
    chk("odd_latency", 32'(lat), 32'd9);
    chk_cnt("odd", 8, 3, 2);
    chk_wr("odd_w0", b_wr, 32'hFFFF, 32'h0000_C0FF, 32'hF);
    chk_wr("odd_w1", b_wr + 1, 32'h0000, 32'h0000_FF00, 32'h3);

    snap();
    stall_n = 5;
    kick(16'h0010, 16'h0040, 16'd2, 6'd2, 1'b1);
    wait_done("bp", lat);
    stall_n = 0;
    chk("bp_latency", 32'(lat), 32'd11);
    chk_cnt("bp", 10, 2, 1);
    chk("bp_stable", 32'(stable_err - b_st), 32'd0);
    chk_wr("bp_w0", b_wr, 32'h40, 32'h8080_90C0, 32'hF);

    snap();
    kick(16'h0010, 16'h0040, 16'd0, 6'd2, 1'b1);
    wait_done("zero", lat);
    chk("zero_latency", 32'(lat), 32'd1);
    chk_cnt("zero", 0, 0, 0);

    snap();
    kick(16'h0010, 16'h0040, 16'd2, 6'd2, 1'b1);
    @(negedge clk);
    cfg_src_base = 16'hFFFE;
    cfg_dst_base = 16'h0080;
    cfg_len      = 16'd4;
    cfg_scale    = 6'd0;
    cfg_relu_en  = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("sbusy", lat);
    repeat (10) @(negedge clk);
    chk_cnt("sbusy", 5, 2, 1);
    chk_wr("sbusy_w0", b_wr, 32'h40, 32'h8080_90C0, 32'hF);

    snap();
    stall_n = 1000;
    kick(16'h0010, 16'h0040, 16'd4, 6'd2, 1'b1);
    w = 0;
    while (!ofm_wr_en && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("rst_in_wr", 32'(ofm_wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_mid");
    stall_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dropped", 32'(q_data.size() - b_wr), 32'd0);

    snap();
    kick(16'h0010, 16'h0040, 16'd2, 6'd2, 1'b1);
    wait_done("post", lat);
    chk("post_latency", 32'(lat), 32'd6);
    chk_cnt("post", 5, 2, 1);
    chk_wr("post_w0", b_wr, 32'h40, 32'h8080_90C0, 32'hF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ppu_seq_ctrl.md
# ppu_seq_ctrl

Sequencer that owns the post-processing unit (PPU) for one output-feature-map tile. On a start pulse it latches a job descriptor, streams 32-bit partial-sum words (two signed 16-bit psums each) from the psum buffer through the combinational PPU, and packs the two int8 results of each PPU pass into dense 32-bit OFM words. It writes those words to the OFM buffer under a ready handshake. It sits between the layer controller, the psum SRAM, the PPU instance and the OFM SRAM write port.

## Interface
- ADDR_BITS, 16, psum/OFM word-address width
- DATA_BITS, 32, data word width; must be 32
- LEN_BITS, 16, job length counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request, sampled only in IDLE
- cfg_src_base  in  ADDR_BITS  first psum word address
- cfg_dst_base  in  ADDR_BITS  first OFM word address
- cfg_len  in  LEN_BITS  number of psum words N
- cfg_scale  in  6  right-shift amount for the PPU
- cfg_relu_en  in  1  ReLU enable for the PPU
- busy  out  1  high from the cycle after start acceptance until DONE
- done  out  1  one-cycle pulse at job end
- psum_rd_en  out  1  psum read strobe
- psum_rd_addr  out  ADDR_BITS  psum read address
- psum_rd_data  in  DATA_BITS  read data, valid exactly one cycle after psum_rd_en
- ppu_data_in  out  DATA_BITS  PPU operand
- ppu_scaling_factor  out  6  latched cfg_scale
- ppu_relu_en  out  1  latched cfg_relu_en
- ppu_need_ppu  out  1  constant 1 while busy, 0 otherwise
- ppu_WEB  out  4  4'b1111 while busy, 4'b0000 otherwise
- ppu_data_out  in  DATA_BITS  PPU result; int8 values in bytes 0 and 2
- ofm_wr_en  out  1  OFM write request
- ofm_wr_addr  out  ADDR_BITS  OFM word address
- ofm_wr_data  out  DATA_BITS  packed OFM word
- ofm_byte_en  out  4  active-high byte enables
- ofm_wr_ready  in  1  OFM port accepts the write this cycle

## Operation
- FSM states: IDLE, RD, CAP, WR, DONE.
- IDLE:
  - On start=1, latch all cfg_* inputs. Clear the src index i, the dst pointer, and the pack register.
  - Go to RD if cfg_len≠0, else go to DONE.
  - start is ignored in every other state. cfg_* changes after acceptance have no effect.
- RD: assert psum_rd_en with psum_rd_addr = src_base + i, then go to CAP.
- CAP:
  - Drive ppu_data_in = psum_rd_data combinationally and take r = {ppu_data_out[23:16], ppu_data_out[7:0]}.
  - If i is even, load pack[15:0] = r. If i is odd, load pack[31:16] = r.
  - Increment i.
  - Go to WR if i was odd or i was the last word (i = N−1). Otherwise go to RD.
- WR:
  - Hold ofm_wr_en=1, ofm_wr_addr = dst_base + dst_idx, ofm_wr_data = pack, until ofm_wr_ready=1.
  - ofm_byte_en = 4'b1111 for a full pair. For the trailing word of an odd N it is 4'b0011 and pack[31:16] = 0.
  - On the handshake: increment dst_idx, clear pack, then go to RD if i<N, else go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_BITS with no error.
- Total OFM words written = ceil(N/2).
- Reset (asynchronous, any state):
  - Return to IDLE and clear all counters, pack and latched cfg.
  - Every output reads 0, including ppu_WEB=0 and ppu_need_ppu=0.
  - A write in progress is dropped; it is not completed later.

## Timing
- Start accepted at edge T0: busy=1 from T0+1.
- Without stalls, the FSM is busy for 2N + ceil(N/2) cycles; done is high in the cycle after the last WR handshake.
- Each extra cycle with ofm_wr_ready=0 in WR adds one cycle. No reads are issued during WR.
- N=0: busy never rises; done pulses in the cycle after acceptance.
- psum read latency is exactly 1. At most one read is outstanding, so no skid buffer is needed.
- The PPU path is combinational within CAP; the pack register is the only pipeline stage.
- ofm_wr_en, ofm_wr_addr, ofm_wr_data and ofm_byte_en are registered and stay stable throughout WR.

## Test plan
- **Single pair.** N=2, scale=2, relu=1, psum[0]=0x0040_0100, psum[1]=0xFF00_FF00 -> one write to dst_base of 0x8080_90C0 with byte_en 4'b1111; done 6 cycles after busy rises.
- **ReLU off.** Same data with relu=0 -> written word 0x4040_90C0.
- **Odd length.** N=3 -> two writes; the second has byte_en 4'b0011 and upper half 0; 8 busy cycles.
- **Backpressure.** ofm_wr_ready held low 5 cycles on the first WR -> wr_en, addr and data stay constant; the write completes once; done is delayed by 5 cycles.
- **Zero length and start-while-busy.** N=0 -> no psum_rd_en, done one cycle later. Separately, a second start mid-job -> ignored; the cfg of the first job is used throughout.
- **Reset mid-job.** rst_n asserted while in WR of N=4 -> all outputs 0 immediately. After release, a new start with N=2 produces the correct single write.
